map_color_checker: RTL and testbench
====================================

MAP_COLOR_CHECKER -- requirements
Module: map_color_checker

Interface
REQ-001 Parameter NUM_REGIONS, default 5: number of map regions.
REQ-002 Parameter COLOR_BITS, default 2: bits per region colour.
REQ-003 Parameter MAX_EDGES, default 16: edge-table depth. EW = clog2(MAX_EDGES), RW = clog2(NUM_REGIONS).
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 edge_wr_en  in  1  write one edge-table entry.
REQ-008 edge_wr_idx  in  EW  entry index written.
REQ-009 edge_a, edge_b  in  RW each  region endpoints of the entry.
REQ-010 num_edges  in  EW+1  active edge count, sampled at start.
REQ-011 colors  in  NUM_REGIONS*COLOR_BITS  flat colouring; region r occupies bits [r*COLOR_BITS +: COLOR_BITS]; sampled at start.
REQ-012 stop_on_first  in  1  early-exit mode, sampled at start.
REQ-013 start  in  1  begin a check (honoured only in IDLE).
REQ-014 busy  out  1  high in CHECK.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 valid  out  1  colouring valid (no conflict found).
REQ-017 conflict_count  out  EW+1  conflicting edges found.
REQ-018 first_bad_edge  out  EW  index of lowest conflicting edge; 0 if none.

Function
REQ-019 FSM states SHALL be IDLE, CHECK, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-020 IDLE with start=1 at cycle T: SHALL register colors, num_edges (clamped to MAX_EDGES), stop_on_first; clear valid, conflict_count, first_bad_edge; enter CHECK at T+1, or DONE at T+1 if num_edges=0.
REQ-021 CHECK SHALL evaluate edge k in cycle T+1+k, one edge per cycle, ascending index.
REQ-022 Edge k SHALL be a conflict if colour[a]==colour[b], a==b, or a or b >= NUM_REGIONS.
REQ-023 On conflict: conflict_count increments (saturating at MAX_EDGES); first_bad_edge captures k on the first conflict only.
REQ-024 After the last edge, or after the first conflict when stop_on_first=1, the FSM SHALL enter DONE; done is therefore asserted in cycle T+1+num_edges, or T+2+k for early exit at edge k.
REQ-025 In DONE: done=1; valid=1 iff conflict_count==0; valid, conflict_count and first_bad_edge hold until the next accepted start.
REQ-026 start outside IDLE SHALL be ignored; start in the DONE cycle is ignored.
REQ-027 edge_wr_en SHALL write in IDLE and DONE only; writes during CHECK are dropped; edge_wr_idx >= MAX_EDGES is dropped.
REQ-028 colors/num_edges changes after start SHALL NOT affect the running check.

Reset
REQ-029 rst SHALL force IDLE, busy=0, done=0, valid=0, conflict_count=0, first_bad_edge=0, in the cycle it is sampled, including mid-CHECK.
REQ-030 Edge-table contents SHALL NOT be reset; they persist across rst.

Structure
REQ-031 Package map_color_pkg SHALL hold the state enum (IDLE, CHECK, DONE) and width helper functions.
REQ-032 Edge table SHALL be a sub-module map_edge_ram (MAX_EDGES x 2*RW, one write port, one asynchronous read port).
REQ-033 Colour lookup SHALL use indexed part-selects of the registered colour vector.

Verification
REQ-034 Load Oz map edges 0..7 = (G,W)(W,Q)(Q,M)(M,G)(E,G)(E,W)(E,Q)(E,M) with G=0,W=1,Q=2,M=3,E=4; colors G=0,W=1,Q=0,M=1,E=2, num_edges=8, start at T -> done at T+9, valid=1, count=0.
REQ-035 Same, E=0 -> done at T+9, valid=0, count=2, first_bad_edge=4.
REQ-036 Same as REQ-035 with stop_on_first=1 -> done at T+6, count=1, first_bad_edge=4.
REQ-037 num_edges=0 -> done at T+1, valid=1; edge entry (3,3) or (2,7) with num_edges=1 -> valid=0, count=1.
REQ-038 rst asserted at T+4 mid-CHECK -> IDLE at T+5, outputs zero, no done; new start then completes normally with unchanged edge table.
REQ-039 edge_wr_en and start pulsed during CHECK -> table unchanged, running check result unaffected.

Source files
------------

// File: rtl/map_color_pkg.sv
// Shared types and width helpers for the map colouring checker.
package map_color_pkg;

   typedef enum logic [1:0] {IDLE, CHECK, DONE} state_e;

   // Index width for a table of n entries; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Counter width able to hold the value n itself.
   function automatic int cnt_w(input int n);
      return idx_w(n) + 1;
   endfunction

endpackage

// File: rtl/map_color_checker_if.sv
// Control/status bundle between a host and the colouring checker.
interface map_color_checker_if
   import map_color_pkg::*;
#(
   parameter int NUM_REGIONS = 5,
   parameter int COLOR_BITS  = 2,
   parameter int MAX_EDGES   = 16
) ();
   localparam int EW = idx_w(MAX_EDGES);
   localparam int RW = idx_w(NUM_REGIONS);

   logic                              edge_wr_en;
   logic [EW-1:0]                     edge_wr_idx;
   logic [RW-1:0]                     edge_a;
   logic [RW-1:0]                     edge_b;
   logic [EW:0]                       num_edges;
   logic [NUM_REGIONS*COLOR_BITS-1:0] colors;
   logic                              stop_on_first;
   logic                              start;
   logic                              busy;
   logic                              done;
   logic                              valid;
   logic [EW:0]                       conflict_count;
   logic [EW-1:0]                     first_bad_edge;

   modport master (
      output edge_wr_en, edge_wr_idx, edge_a, edge_b, num_edges, colors,
             stop_on_first, start,
      input  busy, done, valid, conflict_count, first_bad_edge
   );

   modport slave (
      input  edge_wr_en, edge_wr_idx, edge_a, edge_b, num_edges, colors,
             stop_on_first, start,
      output busy, done, valid, conflict_count, first_bad_edge
   );
endinterface

// File: rtl/map_edge_ram.sv
// Edge table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded map survives rst.
module map_edge_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 6
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem_q [DEPTH];

   // Write one entry; addresses beyond the table are dropped.
   always_ff @(posedge clk) begin
      if (we_i && (int'(waddr_i) < DEPTH)) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/map_color_checker.sv
// Walks the edge table one entry per cycle and flags edges whose endpoints
// share a colour, are identical, or name a region that does not exist.
module map_color_checker
   import map_color_pkg::*;
#(
   parameter int NUM_REGIONS = 5,
   parameter int COLOR_BITS  = 2,
   parameter int MAX_EDGES   = 16
) (
   input  logic                clk,
   input  logic                rst,
   map_color_checker_if.slave  bus
);
   localparam int EW = idx_w(MAX_EDGES);
   localparam int RW = idx_w(NUM_REGIONS);
   localparam int CW = EW + 1;
   localparam int CB = COLOR_BITS;
   localparam int NC = NUM_REGIONS * COLOR_BITS;

   state_e         state_q;
   logic [NC-1:0]  colors_q;
   logic [CW-1:0]  n_q;
   logic           stop_q;
   logic [EW-1:0]  idx_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [EW-1:0]  fbe_q;
   logic           busy_q, done_q, valid_q;

   logic [2*RW-1:0] ent;
   logic [RW-1:0]   ea, eb;
   logic            a_ok, b_ok, hit, last;
   logic [CB-1:0]   ca, cb;
   logic [CW-1:0]   n_in;

   // Table writes are frozen while a check walks it.
   map_edge_ram #(.DEPTH(MAX_EDGES), .AW(EW), .DW(2*RW)) u_ram (
      .clk     (clk),
      .we_i    (bus.edge_wr_en && (state_q != CHECK)),
      .waddr_i (bus.edge_wr_idx),
      .wdata_i ({bus.edge_a, bus.edge_b}),
      .raddr_i (idx_q),
      .rdata_o (ent)
   );

   assign ea = ent[2*RW-1:RW];
   assign eb = ent[RW-1:0];

   // Evaluate the current edge and form the next conflict count.
   always_comb begin
      a_ok  = ({1'b0, ea} < (RW+1)'(NUM_REGIONS));
      b_ok  = ({1'b0, eb} < (RW+1)'(NUM_REGIONS));
      // Out-of-range endpoints read region 0; the edge is a conflict anyway.
      ca    = colors_q[(a_ok ? int'(ea) : 0) * CB +: CB];
      cb    = colors_q[(b_ok ? int'(eb) : 0) * CB +: CB];
      hit   = !a_ok || !b_ok || (ea == eb) || (ca == cb);
      last  = ((CW'(idx_q) + CW'(1)) >= n_q);
      cnt_d = cnt_q;
      if (hit && (cnt_q != CW'(MAX_EDGES))) cnt_d = cnt_q + CW'(1);
      n_in  = (bus.num_edges > CW'(MAX_EDGES)) ? CW'(MAX_EDGES) : bus.num_edges;
   end

   // Control FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         colors_q <= '0;
         n_q      <= '0;
         stop_q   <= 1'b0;
         idx_q    <= '0;
         cnt_q    <= '0;
         fbe_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  colors_q <= bus.colors;
                  n_q      <= n_in;
                  stop_q   <= bus.stop_on_first;
                  idx_q    <= '0;
                  cnt_q    <= '0;
                  fbe_q    <= '0;
                  if (n_in == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= CHECK;
                     busy_q  <= 1'b1;
                     valid_q <= 1'b0;
                  end
               end
            end
            CHECK: begin
               idx_q <= idx_q + EW'(1);
               cnt_q <= cnt_d;
               if (hit && (cnt_q == '0)) fbe_q <= idx_q;
               if (last || (hit && stop_q)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  valid_q <= (cnt_d == '0);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.valid          = valid_q;
   assign bus.conflict_count = cnt_q;
   assign bus.first_bad_edge = fbe_q;
endmodule

// File: tb/tb_map_color_checker.sv
// Bench for map_color_checker: vector table plus hand sequences, with a
// scoreboard queue of expected completions checked whenever done pulses.
module tb_map_color_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   map_color_checker_if ifc ();
   map_color_checker dut (.clk(clk), .rst(rst), .bus(ifc));

   // Oz map colourings: region r at bits [2r +: 2], order {E,M,Q,W,G}.
   localparam logic [9:0] OZ_OK  = {2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
   localparam logic [9:0] OZ_BAD = {2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
   localparam logic [9:0] ZERO   = 10'd0;

   typedef struct {
      logic       v;
      logic [4:0] cnt;
      logic [3:0] fbe;
      int         due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [9:0] colors;
      logic [4:0] n;
      logic       stop;
      logic       v;
      logic [4:0] cnt;
      logic [3:0] fbe;
      int         lat;
   } vec_t;
   vec_t vecs[11];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard: each done pulse retires the oldest expected completion.
   always @(negedge clk) begin
      if (ifc.done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("valid", int'(ifc.valid), int'(e.v));
            chk("conflict_count", int'(ifc.conflict_count), int'(e.cnt));
            chk("first_bad_edge", int'(ifc.first_bad_edge), int'(e.fbe));
            chk("done_cycle", cyc, e.due);
         end
      end
   end

   task automatic wr(input int idx, input int a, input int b);
      ifc.edge_wr_en  = 1'b1;
      ifc.edge_wr_idx = 4'(idx);
      ifc.edge_a      = 3'(a);
      ifc.edge_b      = 3'(b);
      @(negedge clk);
      ifc.edge_wr_en  = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: got no done, expected %0d pending (cycle %0d)", sb.size(), cyc);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [9:0] c, input logic [4:0] n, input logic s,
                      input logic v, input logic [4:0] cnt, input logic [3:0] f,
                      input int lat);
      ifc.colors        = c;
      ifc.num_edges     = n;
      ifc.stop_on_first = s;
      ifc.start         = 1'b1;
      sb.push_back('{v, cnt, f, cyc + lat});
      @(negedge clk);
      ifc.start = 1'b0;
      wait_drain();
   endtask

   initial begin
      ifc.edge_wr_en = 1'b0; ifc.edge_wr_idx = '0; ifc.edge_a = '0; ifc.edge_b = '0;
      ifc.num_edges = '0; ifc.colors = '0; ifc.stop_on_first = 1'b0; ifc.start = 1'b0;

      vecs[0]  = '{OZ_OK,  5'd8,  1'b0, 1'b1, 5'd0,  4'd0, 9};
      vecs[1]  = '{OZ_BAD, 5'd8,  1'b0, 1'b0, 5'd2,  4'd4, 9};
      vecs[2]  = '{OZ_BAD, 5'd8,  1'b1, 1'b0, 5'd1,  4'd4, 6};
      vecs[3]  = '{OZ_OK,  5'd0,  1'b0, 1'b1, 5'd0,  4'd0, 1};
      vecs[4]  = '{ZERO,   5'd8,  1'b0, 1'b0, 5'd8,  4'd0, 9};
      vecs[5]  = '{ZERO,   5'd8,  1'b1, 1'b0, 5'd1,  4'd0, 2};
      vecs[6]  = '{OZ_BAD, 5'd3,  1'b0, 1'b1, 5'd0,  4'd0, 4};
      vecs[7]  = '{OZ_BAD, 5'd5,  1'b0, 1'b0, 5'd1,  4'd4, 6};
      vecs[8]  = '{OZ_OK,  5'd31, 1'b0, 1'b1, 5'd0,  4'd0, 17};
      vecs[9]  = '{ZERO,   5'd31, 1'b0, 1'b0, 5'd16, 4'd0, 17};
      vecs[10] = '{OZ_BAD, 5'd31, 1'b1, 1'b0, 5'd1,  4'd4, 6};

      repeat (2) @(negedge clk);
      chk("rst_busy", int'(ifc.busy), 0);
      chk("rst_done", int'(ifc.done), 0);
      chk("rst_valid", int'(ifc.valid), 0);
      chk("rst_count", int'(ifc.conflict_count), 0);
      chk("rst_fbe", int'(ifc.first_bad_edge), 0);
      rst = 1'b0;
      @(negedge clk);

      // Oz map in entries 0..7, filler (G,W) in 8..15.
      wr(0, 0, 1); wr(1, 1, 2); wr(2, 2, 3); wr(3, 3, 0);
      wr(4, 4, 0); wr(5, 4, 1); wr(6, 4, 2); wr(7, 4, 3);
      for (int i = 8; i < 16; i++) wr(i, 0, 1);

      foreach (vecs[i])
         run(vecs[i].colors, vecs[i].n, vecs[i].stop, vecs[i].v,
             vecs[i].cnt, vecs[i].fbe, vecs[i].lat);

      // Self-loop and out-of-range endpoint entries.
      wr(0, 3, 3);
      run(OZ_OK, 5'd1, 1'b0, 1'b0, 5'd1, 4'd0, 2);
      wr(0, 2, 7);
      run(OZ_OK, 5'd1, 1'b0, 1'b0, 5'd1, 4'd0, 2);
      wr(0, 0, 1);

      // Reset mid-check: count is non-zero when rst lands, no done follows.
      ifc.colors = ZERO; ifc.num_edges = 5'd8; ifc.stop_on_first = 1'b0;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("midcheck_busy", int'(ifc.busy), 1);
      chk("midcheck_count", int'(ifc.conflict_count), 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("postrst_busy", int'(ifc.busy), 0);
      chk("postrst_done", int'(ifc.done), 0);
      chk("postrst_valid", int'(ifc.valid), 0);
      chk("postrst_count", int'(ifc.conflict_count), 0);
      chk("postrst_fbe", int'(ifc.first_bad_edge), 0);
      repeat (12) @(negedge clk);
      run(OZ_OK,  5'd8, 1'b0, 1'b1, 5'd0, 4'd0, 9);
      run(OZ_BAD, 5'd8, 1'b0, 1'b0, 5'd2, 4'd4, 9);

      // Write, start and input changes during CHECK must not disturb anything.
      ifc.colors = OZ_BAD; ifc.num_edges = 5'd8; ifc.stop_on_first = 1'b0;
      ifc.start = 1'b1;
      sb.push_back('{1'b0, 5'd2, 4'd4, cyc + 9});
      @(negedge clk);
      ifc.edge_wr_en = 1'b1; ifc.edge_wr_idx = 4'd4; ifc.edge_a = 3'd1; ifc.edge_b = 3'd2;
      ifc.colors = ZERO; ifc.num_edges = 5'd1; ifc.stop_on_first = 1'b1;
      @(negedge clk);
      ifc.edge_wr_en = 1'b0; ifc.start = 1'b0;
      wait_drain();
      run(OZ_BAD, 5'd8, 1'b0, 1'b0, 5'd2, 4'd4, 9);

      // Start held through the DONE cycle is ignored there.
      ifc.colors = OZ_OK; ifc.num_edges = 5'd0; ifc.start = 1'b1;
      sb.push_back('{1'b1, 5'd0, 4'd0, cyc + 1});
      @(negedge clk);
      ifc.num_edges = 5'd8;
      @(negedge clk);
      ifc.start = 1'b0;
      chk("done_start_ignored", int'(ifc.busy), 0);
      wait_drain();
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
